clk_gate_ctrl: RTL
==================

# clk_gate_ctrl

Clock-gate enable controller that drives the `Enable` input of the latch-based clock gate in front of a gated functional unit (the ALU path). It wakes the gated clock on a request, waits a fixed settle time before declaring the unit ready, and holds the clock on for a programmable idle window before gating it off. A DFT test-mode input forces the gate open without disturbing the FSM. It sits between the system controller (requester) and the clock gate cell.

## Interface
- `WAKE_CYCLES`, default 2: cycles from wake to `Ready`. Legal range 1..15.
- `IDLE_CYCLES`, default 4: idle cycles before the gate closes. Legal range 0..255.
- `CNT_W`, default 8: internal down-counter width. Must hold max(`WAKE_CYCLES`, `IDLE_CYCLES`).

- `CLK` in 1: single clock. All state is on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `Req` in 1: level. Requester wants the gated clock running.
- `Busy` in 1: level from the gated unit. An operation is in flight; keeps the clock on.
- `Test_Mode` in 1: DFT override. Forces `Gate_EN` high.
- `Gate_EN` out 1: to the clock gate `Enable`; `en_q | Test_Mode`.
- `Ready` out 1: registered. Gated clock is running and settled.
- `Wake_Count` out 8: registered. Saturating count of OFF→WAKE transitions.

## Operation
- The FSM has four states: OFF, WAKE, ON and IDLE. There is one down-counter `cnt`.
  - `en_q` = 1 in WAKE, ON and IDLE; 0 in OFF.
  - `Ready` = 1 in ON only.
- OFF:
  - `Req`=1 → WAKE, `cnt` ← `WAKE_CYCLES`-1, `Wake_Count` += 1 (saturates at 255).
  - `Busy` alone does not wake the clock; this is a protocol violation and is ignored.
- WAKE:
  - `cnt`==0 → ON; otherwise `cnt` decrements.
  - `Req` dropping mid-WAKE does not abort; the FSM still reaches ON, then follows the ON rules.
- ON:
  - `Req|Busy` → stay ON.
  - Otherwise, if `IDLE_CYCLES`==0 → OFF.
  - Otherwise → IDLE, `cnt` ← `IDLE_CYCLES`-1.
- IDLE:
  - `Req|Busy` → ON. The clock was never stopped, so there is no re-settle.
  - Otherwise, `cnt`==0 → OFF.
  - Otherwise `cnt` decrements.
- `Test_Mode` is ORed combinationally into `Gate_EN` only. The FSM, `Ready` and `Wake_Count` are unaffected.
- `RST`=1 on an edge forces OFF, `cnt`=0, `en_q`=0, `Ready`=0 and `Wake_Count`=0, regardless of current state. This includes reset mid-WAKE or mid-ON.
- Reset values of outputs:
  - `Ready`=0, `Wake_Count`=0.
  - `Gate_EN` = `Test_Mode`.

## Timing
- `en_q` and `Ready` are flops. The clock gate latches `Enable` while `CLK` is low, so `en_q` changing after a rising edge reaches the gated clock on the next high phase with no glitch.
- Wake latency:
  - `Req` sampled high in OFF at edge k gives `Gate_EN`=1 after edge k.
  - `Ready`=1 after edge k+`WAKE_CYCLES`.
- Sleep latency:
  - `Req`=`Busy`=0 sampled in ON at edge m gives `Gate_EN`=0 after edge m+`IDLE_CYCLES`.
  - With `IDLE_CYCLES`=0, `Gate_EN`=0 after edge m.
- Re-request during IDLE at edge j gives `Ready`=1 after edge j.
- Simultaneous `Req` and idle expiry (IDLE, `cnt`==0, `Req`=1): ON wins and the gate stays open.
- A `Req` arriving in the same cycle OFF is entered is seen at the next edge and starts a fresh WAKE.
- Minimum clock-off time is one cycle.

## Test plan
- **Reset:** `RST` for 2 edges with `Test_Mode`=0 → `Gate_EN`=0, `Ready`=0, `Wake_Count`=0. Then set `Test_Mode`=1 → `Gate_EN`=1 the same cycle and `Ready` stays 0.
- **Wake/settle, defaults:** `Req` rises before edge 0 → `Gate_EN`=1 after edge 0, `Ready`=1 after edge 2, `Wake_Count`=1.
- **Idle timeout:** from ON, drop `Req` and `Busy` before edge m → `Ready`=0 after m, `Gate_EN`=1 through edge m+3, `Gate_EN`=0 after edge m+4, state OFF.
- **Busy extension and re-request:**
  - `Req` low, `Busy` high for 10 cycles in ON → stays ON with `Ready`=1 throughout.
  - Then `Busy` low, and `Req` pulses high 2 cycles into IDLE → `Ready`=1 after that edge, `Gate_EN` never drops, `Wake_Count` unchanged.
- **`IDLE_CYCLES`=0, `WAKE_CYCLES`=1:**
  - `Req` 1-cycle pulse → `Gate_EN` high 2 cycles.
  - `Ready` high 1 cycle.
  - Back to OFF.
  - Repeat the pulse 300 times → `Wake_Count` saturates at 255.
- **Reset mid-operation:** assert `RST` during WAKE with `cnt`=1 → OFF, `Gate_EN`=0 and `Ready`=0 after that edge. `Req` held high through reset → a new WAKE starts at the first edge after `RST` falls.

Source files
------------

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gate_ctrl
// Brief    : Enable controller for a latch-based clock gate: wake, settle,
//            idle hold-off and DFT force-open.
// Revision : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl #(
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Req,
    input  logic       Busy,
    input  logic       Test_Mode,
    output logic       Gate_EN,
    output logic       Ready,
    output logic [7:0] Wake_Count
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_IDLE_LOAD =
        CNT_W'((IDLE_CYCLES == 0) ? 0 : (IDLE_CYCLES - 1));
    localparam bit               c_NO_IDLE   = (IDLE_CYCLES == 0);
    localparam logic [7:0]       c_WC_MAX    = 8'hFF;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_wake_count;
    logic [7:0]       w_wake_count_nxt;
    logic             r_en_q;
    logic             r_ready;
    logic             w_keep_on;

    assign w_keep_on = Req | Busy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_OFF;
            r_cnt        <= '0;
            r_wake_count <= '0;
            r_en_q       <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_wake_count <= w_wake_count_nxt;
            // Outputs are decoded from the next state so they line up with it.
            r_en_q       <= (w_state_nxt != ST_OFF);
            r_ready      <= (w_state_nxt == ST_ON);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_wake_count_nxt = r_wake_count;
        case (r_state)
            ST_OFF: begin
                // Busy without Req is a protocol violation and is ignored.
                if (Req) begin
                    w_state_nxt = ST_WAKE;
                    w_cnt_nxt   = c_WAKE_LOAD;
                    if (r_wake_count != c_WC_MAX) begin
                        w_wake_count_nxt = r_wake_count + 8'd1;
                    end
                end
            end
            ST_WAKE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_ON;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_ON: begin
                if (!w_keep_on) begin
                    if (c_NO_IDLE) begin
                        w_state_nxt = ST_OFF;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = c_IDLE_LOAD;
                    end
                end
            end
            ST_IDLE: begin
                // Clock never stopped here, so a re-request skips the settle.
                if (w_keep_on) begin
                    w_state_nxt = ST_ON;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_OFF;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    assign Gate_EN    = r_en_q | Test_Mode;
    assign Ready      = r_ready;
    assign Wake_Count = r_wake_count;

endmodule
`default_nettype wire
